// File: rtl/rom_frame_reader.sv
// rom_frame_reader: raster-order read master for the R/G/B image ROMs.
// Issues one ROM address per cycle while the output FIFO has room for every
// in-flight read, merges the three channel bytes and streams 24-bit pixels
// with start-of-frame / end-of-line markers over a valid/ready interface.
// Optional feature: define IMG_TESTPAT_EN to replace ROM data with eight
// vertical colour bars (addressing, timing and markers are unchanged).
module rom_frame_reader #(
  parameter int IMG_W   = 400,
  parameter int IMG_H   = 400,
  parameter int ADDR_W  = 32,
  parameter int ROM_LAT = 1,
  parameter int FIFO_D  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_r,
  input  logic [7:0]        rom_g,
  input  logic [7:0]        rom_b,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [23:0]       m_data,
  output logic              m_sof,
  output logic              m_eol
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + ROM_LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Side information that travels alongside a ROM read until its data returns.
  typedef struct packed {
    logic        sof;
    logic        eol;
`ifdef IMG_TESTPAT_EN
    logic [23:0] pat;
`endif
  } tag_t;

  typedef struct packed {
    logic [23:0] data;
    logic        sof;
    logic        eol;
  } entry_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [ROM_LAT-1:0] pipe_vld;
  tag_t            pipe_tag [ROM_LAT];
  tag_t            tag_new;
  entry_t          mem [FIFO_D];
  entry_t          push_entry;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_count, inflight;
  logic            start_ok, issue, push, pop, last_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Count reads still travelling through the ROM latency pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) inflight += CW'(pipe_vld[i]);
  end

  assign start_ok = (state_q == IDLE) && !frame_done && start;
  assign issue    = (state_q == RUN) && ((fifo_count + inflight) < CW'(FIFO_D));
  assign push     = pipe_vld[ROM_LAT-1];
  assign pop      = m_valid && m_ready;
  assign last_pop = (state_q == DRAIN) && (inflight == '0) &&
                    (fifo_count == CW'(1)) && pop;

  // Markers (and the test pattern) are fixed at issue time from the raster position.
  always_comb begin
    tag_new     = '0;
    tag_new.sof = (x_q == '0) && (y_q == '0);
    tag_new.eol = (x_q == XW'(IMG_W - 1));
`ifdef IMG_TESTPAT_EN
    begin
      logic [2:0] bar;
      bar = 3'((32'(x_q) * 8) / IMG_W);
      tag_new.pat = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
    end
`endif
  end

  // Assemble the FIFO entry from the emerging tag and the returned ROM data.
  always_comb begin
    push_entry     = '0;
    push_entry.sof = pipe_tag[ROM_LAT-1].sof;
    push_entry.eol = pipe_tag[ROM_LAT-1].eol;
`ifdef IMG_TESTPAT_EN
    push_entry.data = pipe_tag[ROM_LAT-1].pat;
`else
    push_entry.data = {rom_r, rom_g, rom_b};
`endif
  end

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (issue && (rom_addr == LAST_ADDR)) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address counter and raster position; address saturates at the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (start_ok) begin
      rom_addr <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (issue) begin
      if (rom_addr != LAST_ADDR) rom_addr <= rom_addr + 1'b1;
      if (x_q == XW'(IMG_W - 1)) begin
        x_q <= '0;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  // Issue-valid tag pipe matching the ROM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < ROM_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_vld[0] <= issue;
      pipe_tag[0] <= tag_new;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  // Output FIFO; push and pop may coincide, including when full.
  // NOTE: the storage is reset because its head drives m_data, which must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_D; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Completion pulse one cycle after the final handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= last_pop;
  end

  assign busy    = (state_q != IDLE) || frame_done;
  assign m_valid = (fifo_count != '0);
  assign m_data  = mem[rd_ptr].data;
  assign m_sof   = mem[rd_ptr].sof;
  assign m_eol   = mem[rd_ptr].eol;

endmodule

// File: tb/tb_rom_frame_reader.sv
// Directed testbench for rom_frame_reader with a small 4x2 frame (8x2 when
// IMG_TESTPAT_EN is defined). ROM model: r=addr, g=addr+0x10, b=addr+0x20.
module tb_rom_frame_reader;

`ifdef IMG_TESTPAT_EN
  localparam int W = 8;
`else
  localparam int W = 4;
`endif
  localparam int H    = 2;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, frame_done;
  logic [31:0] rom_addr;
  logic [7:0]  rom_r = 8'h0, rom_g = 8'h0, rom_b = 8'h0;
  logic        m_valid, m_ready = 1'b0;
  logic [23:0] m_data;
  logic        m_sof, m_eol;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rom_frame_reader #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(32), .ROM_LAT(1), .FIFO_D(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
    .rom_addr(rom_addr), .rom_r(rom_r), .rom_g(rom_g), .rom_b(rom_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol)
  );

  always #5 clk = ~clk;

  // One-cycle-latency ROMs.
  always @(posedge clk) begin
    rom_r <= rom_addr[7:0];
    rom_g <= rom_addr[7:0] + 8'h10;
    rom_b <= rom_addr[7:0] + 8'h20;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] exp_pix(input int i);
    logic [7:0] a;
    logic [2:0] k;
    a = 8'(i);
    k = 3'(((i % W) * 8) / W);
`ifdef IMG_TESTPAT_EN
    return {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
`else
    return {a, a + 8'h10, a + 8'h20};
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    total_cnt++;
    if ({busy, frame_done, m_valid, m_sof, m_eol} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {busy, frame_done, m_valid, m_sof, m_eol});
    else pass_cnt++;
    total_cnt++;
    if (rom_addr !== 32'd0) $display("FAIL reset_addr got %0d want 0", rom_addr);
    else pass_cnt++;
    total_cnt++;
    if (m_data !== 24'h0) $display("FAIL reset_data got %06h want 000000", m_data);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  // mode 0: ready always 1; 1: random ready; 2: ready held low for 20 cycles.
  // poke: also pulse start mid-frame and on the frame_done cycle.
  task automatic run_frame(input int mode, input bit poke, input string name);
    int idx = 0;
    int cyc = 0;
    int first_valid = -1;
    bit done = 1'b0;
    bit stalled = 1'b0;
    logic [23:0] held = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    total_cnt++;
    if (rom_addr !== 32'd0 || busy !== 1'b1) $display("FAIL %s_start addr=%0d busy=%b want addr=0 busy=1", name, rom_addr, busy);
    else pass_cnt++;
    while (!done && cyc < 400) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = (cyc >= 20);
      endcase
      start = poke && (cyc == 5);
      if (stalled) begin
        total_cnt++;
        if (m_valid !== 1'b1 || m_data !== held) $display("FAIL %s_stable cyc=%0d valid=%b data=%06h want 1 %06h", name, cyc, m_valid, m_data, held);
        else pass_cnt++;
      end
      if (m_valid && first_valid < 0) begin
        first_valid = cyc;
        if (mode == 0) begin
          total_cnt++;
          if (cyc !== 2) $display("FAIL %s_latency first valid at cyc %0d want 2", name, cyc);
          else pass_cnt++;
        end
      end
      if (mode == 2 && cyc == 19) begin
        total_cnt++;
        if (rom_addr !== 32'd3 || idx !== 0) $display("FAIL %s_frozen addr=%0d pops=%0d want addr=3 pops=0", name, rom_addr, idx);
        else pass_cnt++;
      end
      if (m_valid && m_ready) begin
        total_cnt++;
        if (idx >= NPIX) $display("FAIL %s_extra got pixel beyond %0d want none", name, NPIX);
        else if (m_data !== exp_pix(idx) || m_sof !== (idx == 0) || m_eol !== ((idx % W) == W - 1))
          $display("FAIL %s_pix%0d got %06h sof=%b eol=%b want %06h sof=%b eol=%b", name, idx, m_data, m_sof, m_eol,
                   exp_pix(idx), (idx == 0), ((idx % W) == W - 1));
        else if (mode == 0 && cyc !== idx + 2) $display("FAIL %s_bubble pix%0d at cyc %0d want %0d", name, idx, cyc, idx + 2);
        else pass_cnt++;
        idx++;
      end
      stalled = m_valid && !m_ready;
      held = m_data;
      if (frame_done) begin
        done = 1'b1;
        total_cnt++;
        if (idx !== NPIX || busy !== 1'b1) $display("FAIL %s_done pixels=%0d busy=%b want %0d 1", name, idx, busy, NPIX);
        else pass_cnt++;
        start = poke;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    m_ready = 1'b0;
    total_cnt++;
    if (!done) $display("FAIL %s_timeout no frame_done after %0d cycles", name, cyc);
    else if (busy !== 1'b0 || frame_done !== 1'b0) $display("FAIL %s_idle busy=%b done=%b want 0 0", name, busy, frame_done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    run_frame(0, 1'b0, "basic");
  endtask

  task automatic test_random_ready();
    for (int f = 0; f < 200; f++) run_frame(1, 1'b0, "random");
  endtask

  task automatic test_full_stall();
    run_frame(2, 1'b0, "stall");
  endtask

  task automatic test_start_ignored();
    run_frame(0, 1'b1, "poke");
    run_frame(0, 1'b0, "restart");
  endtask

  task automatic test_mid_reset();
    int idx = 0;
    int cyc = 0;
    bit seen_done = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    m_ready = 1'b1;
    while (idx < 5 && cyc < 50) begin
      if (m_valid && m_ready) idx++;
      step();
      cyc++;
    end
    total_cnt++;
    if (idx !== 5) $display("FAIL midrst_reach pops=%0d want 5", idx);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, frame_done, m_valid, m_sof, m_eol} !== 5'b0 || rom_addr !== 32'd0 || m_data !== 24'h0)
      $display("FAIL midrst_outputs flags=%b addr=%0d data=%06h want 00000 0 000000",
               {busy, frame_done, m_valid, m_sof, m_eol}, rom_addr, m_data);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (frame_done) seen_done = 1'b1;
      step();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (frame_done) seen_done = 1'b1;
      step();
    end
    total_cnt++;
    if (seen_done !== 1'b0) $display("FAIL midrst_nodone got frame_done=1 want 0");
    else pass_cnt++;
    m_ready = 1'b0;
    run_frame(0, 1'b0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_random_ready();
    test_full_stall();
    test_start_ignored();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
